// File: rtl/keypad_pkg.sv
// Shared types and helpers for the decimal keypad path: FSM states and one-hot to BCD encoding.
package keypad_pkg;

    localparam int unsigned BcdW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StWaitRel
    } key_state_e;

    typedef struct packed {
        logic [BcdW-1:0] bcd;
        logic            is_onehot;
    } bcd_res_t;

    function automatic logic is_onehot(input logic [9:0] oh);
        return (oh != '0) && ((oh & (oh - 10'd1)) == '0);
    endfunction

    // Presence is "any bit set"; d0 encodes to 0000 and is still a valid digit.
    function automatic bcd_res_t onehot_to_bcd(input logic [9:0] oh);
        bcd_res_t r;
        r.bcd = '0;
        for (int i = 0; i < 10; i++) begin
            if (oh[i]) r.bcd = r.bcd | BcdW'(i);
        end
        r.is_onehot = is_onehot(oh);
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_sync.sv
// Two-flop key synchroniser plus press/release debouncer; reports each settled press once.
module key_debounce_sync
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key,
    output logic       accept_pulse,
    output logic [9:0] accept_pat,
    output logic       multi_hit
);

    localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

    logic [9:0] sync1_q, ks_q;
    logic [9:0] pat_q, pat_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept_q, accept_d;
    key_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            ks_q     <= '0;
            pat_q    <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            state_q  <= StIdle;
        end else begin
            sync1_q  <= key;
            ks_q     <= sync1_q;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ks_q != '0) begin
                    pat_d   = ks_q;
                    cnt_d   = 8'd1;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (ks_q == '0) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (ks_q != pat_q) begin
                    pat_d = ks_q;
                    cnt_d = 8'd1;
                end else if (cnt_q == DebLast) begin
                    accept_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StWaitRel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitRel: begin
                // Any activity restarts the release window, so a held key never repeats.
                if (ks_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept_pulse = accept_q;
    assign accept_pat   = pat_q;
    assign multi_hit    = accept_q & ~is_onehot(pat_q);

endmodule

// File: rtl/decimal_key_entry_ctrl.sv
// Keypad entry controller: debounced digits shift into a BCD buffer, presented on ENTER via
// a valid/ack handshake.
module decimal_key_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [9:0]                 key,
    input  logic                       clr,
    input  logic                       enter,
    input  logic                       out_ack,
    output logic                       out_valid,
    output logic [BcdW*NUM_DIGITS-1:0] digits,
    output logic [2:0]                 count,
    output logic                       key_valid,
    output logic [BcdW-1:0]            key_code,
    output logic                       err
);

    localparam int unsigned DigW = BcdW * NUM_DIGITS;
    localparam logic [2:0]  Full = 3'(NUM_DIGITS);

    logic            accept_pulse, multi_hit;
    logic [9:0]      accept_pat;
    bcd_res_t        res;
    logic            flush, eff_valid, eff_full, accept_ok;
    logic [DigW+BcdW-1:0] shifted;

    logic [DigW-1:0] digits_q, digits_d;
    logic [2:0]      count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic            key_valid_q, key_valid_d;
    logic [BcdW-1:0] key_code_q, key_code_d;
    logic            err_q, err_d;

    key_debounce_sync #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .accept_pulse (accept_pulse),
        .accept_pat   (accept_pat),
        .multi_hit    (multi_hit)
    );

    assign res     = onehot_to_bcd(accept_pat);
    assign shifted = {digits_q, res.bcd};

    // Acceptance is judged against the buffer as it stands after CLR / ACK completion, so a
    // press landing on a flush edge still reports its digit even though the flush wins.
    assign flush     = clr | (out_valid_q & out_ack);
    assign eff_valid = out_valid_q & ~flush;
    assign eff_full  = ~flush & (count_q == Full);
    assign accept_ok = accept_pulse & res.is_onehot & ~eff_valid & ~eff_full;

    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        err_d       = 1'b0;

        if (accept_ok) begin
            key_valid_d = 1'b1;
            key_code_d  = res.bcd;
        end else if (accept_pulse) begin
            err_d = multi_hit | eff_valid | eff_full;
        end

        if (flush) begin
            digits_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (accept_ok) begin
                digits_d = shifted[DigW-1:0];
                count_d  = count_q + 3'd1;
            end
            if (enter && !out_valid_q && (count_d != '0)) out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            err_q       <= err_d;
        end
    end

    assign digits    = digits_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign err       = err_q;

endmodule

// File: tb/tb_decimal_key_entry_ctrl.sv
// Self-checking bench for decimal_key_entry_ctrl: press table plus handshake corner sequences.
module tb_decimal_key_entry_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned ND  = 4;
    localparam int          LAT = 3 + DEB;  // posedges from key drive to visible KEY_VALID

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    key;
    logic          clr, enter, out_ack;
    logic          out_valid;
    logic [4*ND-1:0] digits;
    logic [2:0]    count;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          err;

    int errors = 0;
    int checks = 0;
    logic [3:0] sb[$];

    decimal_key_entry_ctrl #(
        .DEB_CYCLES(DEB),
        .NUM_DIGITS(ND)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .clr       (clr),
        .enter     (enter),
        .out_ack   (out_ack),
        .out_valid (out_valid),
        .digits    (digits),
        .count     (count),
        .key_valid (key_valid),
        .key_code  (key_code),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every KEY_VALID pulse must match the next expected code.
    always @(posedge clk) begin : mon
        logic [3:0] e;
        #1;
        if (rst_n && key_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_key_valid", {31'd0, key_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_key_code", {28'd0, key_code}, {28'd0, e});
            end
        end
    end

    // Hold key k for the acceptance window, optionally raising clr/ack/enter for the accept edge,
    // then release and let the release debounce finish.
    task automatic press(input logic [9:0] k, input logic c_clr, input logic c_ack,
                         input logic c_enter, output int nv, output int ne, output int lat);
        nv  = 0;
        ne  = 0;
        lat = 0;
        key = k;
        for (int i = 1; i <= LAT + 4; i++) begin
            if (i == LAT) begin
                clr     = c_clr;
                out_ack = c_ack;
                enter   = c_enter;
            end
            tick();
            clr     = 1'b0;
            out_ack = 1'b0;
            enter   = 1'b0;
            if (key_valid) begin nv++; lat = i; end
            if (err) begin ne++; lat = i; end
        end
        key = '0;
        repeat (DEB + 6) tick();
    endtask

    typedef struct {
        logic [9:0]  k;
        logic        ev;
        logic        ee;
        logic [3:0]  code;
        logic [15:0] dg;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[6];
    int   nv, ne, lat;

    initial begin
        tbl[0] = '{10'h002, 1'b1, 1'b0, 4'd1, 16'h0001, 3'd1};
        tbl[1] = '{10'h200, 1'b1, 1'b0, 4'd9, 16'h0019, 3'd2};
        tbl[2] = '{10'h001, 1'b1, 1'b0, 4'd0, 16'h0190, 3'd3};
        tbl[3] = '{10'h020, 1'b1, 1'b0, 4'd5, 16'h1905, 3'd4};
        tbl[4] = '{10'h008, 1'b0, 1'b1, 4'd0, 16'h1905, 3'd4};  // overflow
        tbl[5] = '{10'h088, 1'b0, 1'b1, 4'd0, 16'h1905, 3'd4};  // multi-key

        rst_n = 1'b0; key = 10'h004; clr = 1'b0; enter = 1'b0; out_ack = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_digits", {16'd0, digits}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Key held through reset release is a fresh press.
        rst_n = 1'b1;
        sb.push_back(4'd2);
        press(10'h004, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        check("held_rst_nv", nv, 1);
        check("held_rst_lat", lat, LAT);
        check("held_rst_digits", {16'd0, digits}, 32'h0002);
        check("held_rst_count", {29'd0, count}, 32'd1);

        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_count", {29'd0, count}, 32'd0);
        check("clr_digits", {16'd0, digits}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].ev) sb.push_back(tbl[i].code);
            press(tbl[i].k, 1'b0, 1'b0, 1'b0, nv, ne, lat);
            check($sformatf("tbl%0d_nv", i), nv, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_ne", i), ne, {31'd0, tbl[i].ee});
            check($sformatf("tbl%0d_lat", i), lat, LAT);
            check($sformatf("tbl%0d_digits", i), {16'd0, digits}, {16'd0, tbl[i].dg});
            check($sformatf("tbl%0d_count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
        end

        // ENTER on an empty buffer is ignored without ERR.
        clr = 1'b1; tick(); clr = 1'b0;
        enter = 1'b1; tick(); enter = 1'b0;
        check("enter_empty_err", {31'd0, err}, 32'd0);
        tick();
        check("enter_empty_valid", {31'd0, out_valid}, 32'd0);

        // Bouncy d7: one pulse, timed from the final stable drive.
        key = 10'h080; tick();
        key = 10'h000; tick();
        sb.push_back(4'd7);
        press(10'h080, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        check("bounce_nv", nv, 1);
        check("bounce_lat", lat, LAT);
        check("bounce_digit", {28'd0, digits[3:0]}, 32'd7);

        sb.push_back(4'd8);
        press(10'h100, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        check("d8_digits", {16'd0, digits}, 32'h0078);

        enter = 1'b1; tick(); enter = 1'b0;
        check("enter_valid", {31'd0, out_valid}, 32'd1);
        check("enter_count", {29'd0, count}, 32'd2);

        // Press while presenting: frozen buffer, ERR.
        press(10'h010, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        check("frozen_nv", nv, 0);
        check("frozen_ne", ne, 1);
        check("frozen_digits", {16'd0, digits}, 32'h0078);
        check("frozen_valid", {31'd0, out_valid}, 32'd1);

        out_ack = 1'b1; tick(); out_ack = 1'b0;
        check("ack_valid", {31'd0, out_valid}, 32'd0);
        check("ack_count", {29'd0, count}, 32'd0);
        check("ack_digits", {16'd0, digits}, 32'd0);

        // Push and ENTER on the same edge: presented number includes the new digit.
        sb.push_back(4'd3);
        press(10'h008, 1'b0, 1'b0, 1'b1, nv, ne, lat);
        check("push_enter_nv", nv, 1);
        check("push_enter_valid", {31'd0, out_valid}, 32'd1);
        check("push_enter_digits", {16'd0, digits}, 32'h0003);

        // CLR + ACK + accept on one edge: buffer empty, KEY_VALID still reported.
        sb.push_back(4'd6);
        press(10'h040, 1'b1, 1'b1, 1'b0, nv, ne, lat);
        check("cak_nv", nv, 1);
        check("cak_ne", ne, 0);
        check("cak_valid", {31'd0, out_valid}, 32'd0);
        check("cak_count", {29'd0, count}, 32'd0);
        check("cak_digits", {16'd0, digits}, 32'd0);
        check("cak_code", {28'd0, key_code}, 32'd6);

        // ACK while not presenting has no effect.
        sb.push_back(4'd5);
        press(10'h020, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        out_ack = 1'b1; tick(); out_ack = 1'b0;
        check("stray_ack_count", {29'd0, count}, 32'd1);
        check("stray_ack_digits", {16'd0, digits}, 32'h0005);

        // Reset asserted mid-press while presenting.
        key = 10'h002;
        repeat (3) tick();
        enter = 1'b1; tick(); enter = 1'b0;
        check("mid_valid_pre", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_digits", {16'd0, digits}, 32'd0);
        check("mid_rst_code", {28'd0, key_code}, 32'd0);
        tick();
        rst_n = 1'b1;
        sb.push_back(4'd1);
        press(10'h002, 1'b0, 1'b0, 1'b0, nv, ne, lat);
        check("mid_fresh_nv", nv, 1);
        check("mid_fresh_lat", lat, LAT);
        check("mid_fresh_count", {29'd0, count}, 32'd1);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decimal_key_entry_ctrl.md
Name: decimal_key_entry_ctrl

Overview:
- Sequencing controller in front of the decimal-to-BCD encoder on the LaunchPad keypad path.
- Synchronises and debounces the ten one-hot key lines d0..d9 and rejects multi-key presses.
- Encodes each accepted press to BCD and shifts it into a NUM_DIGITS entry buffer.
- On ENTER, presents the assembled number to the downstream consumer over a valid/ack handshake.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required for a press or a release to be accepted (legal range 2..255).
- NUM_DIGITS, 4: entry buffer depth in BCD digits (legal range 1..7).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- KEY  in  10  raw key lines; bit n = decimal key n; asynchronous.
- CLR  in  1  synchronous clear of the entry buffer.
- ENTER  in  1  request to present the buffer.
- OUT_ACK  in  1  downstream accept.
- OUT_VALID  out  1  buffer contents presented.
- DIGITS  out  4*NUM_DIGITS  BCD buffer; the most recent digit is in [3:0].
- COUNT  out  3  number of digits held (0..NUM_DIGITS).
- KEY_VALID  out  1  one-cycle pulse when a digit is accepted.
- KEY_CODE  out  4  BCD of the last accepted key.
- ERR  out  1  one-cycle pulse on a rejected press.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, state IDLE, synchroniser flops 0, debounce counter 0.
- Synchroniser: KEY passes through two flops to give KS. All decisions use KS only.
- IDLE:
  - KS != 0: capture PAT = KS, cnt = 1, go to DEBOUNCE.
- DEBOUNCE:
  - KS == 0: go to IDLE.
  - KS != 0 and KS != PAT: PAT = KS, cnt = 1.
  - KS == PAT: cnt increments. When cnt reaches DEB_CYCLES, evaluate PAT and go to WAIT_REL:
    - PAT one-hot, OUT_VALID = 0, COUNT < NUM_DIGITS: shift DIGITS left 4 bits, insert the BCD of PAT at [3:0], COUNT+1, KEY_CODE updated, KEY_VALID pulse.
    - PAT multi-hot, or COUNT == NUM_DIGITS (overflow), or OUT_VALID = 1: buffer unchanged, ERR pulse.
- WAIT_REL:
  - Requires KS == 0 for DEB_CYCLES consecutive cycles, then go to IDLE. Any nonzero KS restarts the release count.
  - Holding a key never produces a repeat digit.
- Latency: a clean key held from edge 0 gives KEY_VALID high in the cycle after edge 2+DEB_CYCLES (synchroniser 2 + debounce DEB_CYCLES).
- Encoding: BCD = one-hot index (d1 -> 0001, d9 -> 1001). The d0 press is a valid digit 0000; presence comes from "any bit set", never from BCD != 0.
- Handshake:
  - ENTER with COUNT > 0 and OUT_VALID = 0 sets OUT_VALID on the next edge.
  - ENTER with COUNT == 0 is ignored; no ERR.
  - While OUT_VALID = 1, DIGITS and COUNT are frozen.
  - OUT_VALID and OUT_ACK both high at an edge: OUT_VALID = 0, DIGITS = 0, COUNT = 0 on that edge.
  - OUT_ACK while OUT_VALID = 0 has no effect.
- CLR: DIGITS = 0, COUNT = 0, OUT_VALID = 0. The key FSM is unaffected.
- Priority within one edge: CLR > OUT_ACK completion > key push > ENTER.
  - If a key push and ENTER coincide, the digit is pushed and OUT_VALID rises on the same edge, including the new digit.
- Reset asserted mid-operation: immediate return to reset values. A key held through reset release is debounced as a fresh press.

Decomposition:
- Shared package (keypad_pkg):
  - state enum {IDLE, DEBOUNCE, WAIT_REL}
  - BCD width constant 4
  - function onehot_to_bcd(10-bit) returning BCD and an is_onehot flag; reusable by the encoder model in benches.
- Sub-module key_debounce_sync:
  - Contains the synchroniser, PAT register, counter and FSM.
  - Emits accept_pulse, accept_pat, multi_hit.
  - The top level holds the buffer, handshake and priority logic.

Test Plan:
- Reset with KEY = 0x004 held: all outputs 0; after release and a DEB_CYCLES-stable press, KEY_VALID pulses once, KEY_CODE = 2, COUNT = 1, DIGITS = 0x0002.
- Bouncy press on d7 (toggling every cycle for 3 cycles, then stable), DEB_CYCLES = 4: exactly one KEY_VALID, 2+4 cycles after the final stable edge; DIGITS[3:0] = 7.
- Press d1, d9, d0, d5 in sequence, then a fifth press d3: DIGITS = 0x1905, COUNT = 4; the fifth press gives an ERR pulse and DIGITS stays 0x1905.
- KEY = 0x088 (d3 + d7) stable: ERR pulse, no KEY_VALID, COUNT unchanged.
- ENTER with COUNT = 2: OUT_VALID = 1 next cycle. Hold OUT_ACK low 5 cycles while pressing d4: DIGITS stays frozen and ERR pulses. Then OUT_ACK = 1: OUT_VALID, COUNT and DIGITS all 0 on the next edge.
- CLR, OUT_ACK and a key accept on the same edge: the buffer ends empty with OUT_VALID = 0; KEY_VALID is still pulsed with the correct KEY_CODE.
